data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder that sits on the memory side of the processor's load/store port. The datapath drives an access with a valid/ready request handshake. The block latches the request, inserts a configurable number of wait states, and performs the word read or write on a banked 16-bit array. It then returns a one-cycle response carrying the read data and an error flag. This lets the core be verified against realistic, non-zero memory latency.

## Interface
- DEPTH, 256: number of 16-bit words; word index = req_addr[15:1]
- WAIT_CYCLES, 2: wait states between acceptance and response; legal range 0..15
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  datapath presents an access
- req_ready  out  1  responder can accept; transfer occurs on an edge where req_valid and req_ready are both 1
- req_we  in  1  1 = store, 0 = load
- req_addr  in  16  byte address; must be even
- req_wdata  in  16  store data
- resp_valid  out  1  one-cycle pulse; response fields valid
- resp_rdata  out  16  load data; 0 for stores and errors
- resp_err  out  1  access rejected (misaligned or out of range)
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE
    - req_ready = 1.
    - On acceptance, latch we, addr, and wdata.
    - Go to WAIT if WAIT_CYCLES > 0 (load counter with WAIT_CYCLES), else go to RESP.
  - WAIT
    - req_ready = 0; the counter decrements each edge.
    - When the counter reaches 1, go to RESP on that edge.
  - RESP
    - resp_valid = 1 for exactly this cycle; req_ready = 0.
    - Unconditional return to IDLE on the next edge.
- Commit happens on the edge entering RESP:
  - Error check: err = latched_addr[0] | (latched_addr[15:1] >= DEPTH).
  - Store with err = 0: mem[addr[15:1]] <= wdata. resp_rdata <= 0.
  - Load with err = 0: resp_rdata <= mem[addr[15:1]].
  - err = 1: no array write, resp_rdata <= 0, resp_err <= 1.
- resp_rdata and resp_err are registered and held until the next commit. Consumers sample them only while resp_valid = 1.
- req_valid, req_we, req_addr, and req_wdata are ignored outside IDLE; changes while busy have no effect on the latched request.
- The array is not reset and its contents are undefined until written. Reset never alters stored words.
- A store followed by a load to the same address returns the stored data; no forwarding path is needed because requests never overlap.

## Timing
- Reset (rst_n = 0) forces: state IDLE, counter 0, req_ready 0, resp_valid 0, resp_rdata 0x0000, resp_err 0, busy 0.
- req_ready rises in the first cycle after rst_n deasserts.
- Latency: with acceptance at edge E0, resp_valid is high in the cycle following edge E0 + WAIT_CYCLES.
- Occupancy: req_ready is low for WAIT_CYCLES + 1 cycles after acceptance. Maximum throughput is one access per WAIT_CYCLES + 2 cycles.
- Reset mid-operation (WAIT or RESP):
  - Immediate return to IDLE with outputs at reset values.
  - A store not yet committed is discarded.
  - A store already committed (state was RESP) remains in the array.
- If req_valid is held high continuously, a new access is accepted on the first edge after the return to IDLE.
- Counter width is 4 bits. WAIT_CYCLES = 0 bypasses WAIT entirely.

## Test plan
- Reset check:
  - Stimulus: rst_n low for 3 cycles with random inputs.
  - Required response: req_ready = 0, resp_valid = 0, resp_rdata = 0x0000, resp_err = 0, busy = 0; req_ready = 1 one cycle after release.
- Store and load with WAIT_CYCLES = 2:
  - Stimulus: store 0x1234 to address 0x0004, then load 0x0004.
  - Required response: each resp_valid appears 3 cycles after acceptance. The store response has resp_rdata = 0, resp_err = 0. The load response has resp_rdata = 0x1234, resp_err = 0.
- Misaligned store:
  - Stimulus: store 0xBEEF to address 0x0005, then load 0x0004.
  - Required response: the store gives resp_err = 1; the load returns 0x1234 (array unchanged).
- Out of range (DEPTH = 256):
  - Stimulus: load address 0x0200 (word 256).
  - Required response: resp_err = 1, resp_rdata = 0x0000.
  - Stimulus: store to 0x01FE.
  - Required response: succeeds with resp_err = 0.
- Reset during WAIT:
  - Stimulus: store 0xAAAA to 0x0010, then assert rst_n one cycle after acceptance; afterwards load 0x0010.
  - Required response: no resp_valid for the store, and the load does not return 0xAAAA (pre-store the location with 0x5555 and expect 0x5555).
  - Also: inputs changed during WAIT have no effect on the latched request.
- Throughput with WAIT_CYCLES = 0:
  - Stimulus: req_valid held high for 4 loads.
  - Required response: resp_valid pulses every 2 cycles, and req_ready alternates 1/0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store memory responder: accepts one word access, waits WAIT_CYCLES,
// commits to a 16-bit word array, then pulses a registered response.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] mem [DEPTH];

  logic        accept;
  logic        cmt_en;
  logic        cmt_we;
  logic        cmt_err;
  logic [15:0] cmt_addr;
  logic [15:0] cmt_wdata;

  function automatic logic addr_err(input logic [15:0] a);
    logic [31:0] word_idx;
    word_idx = {17'd0, a[15:1]};
    return a[0] || (word_idx >= DEPTH);
  endfunction

  assign accept = (state == S_IDLE) && req_valid && req_ready;

  // With zero wait states the commit coincides with acceptance, so the
  // incoming request is used directly instead of the not-yet-latched copy.
  always_comb begin
    cmt_en    = 1'b0;
    cmt_we    = lat_we;
    cmt_addr  = lat_addr;
    cmt_wdata = lat_wdata;
    if (WAIT_CYCLES == 0) begin
      cmt_en    = accept;
      cmt_we    = req_we;
      cmt_addr  = req_addr;
      cmt_wdata = req_wdata;
    end else begin
      cmt_en = (state == S_WAIT) && (cnt == 4'd1);
    end
    cmt_err = addr_err(cmt_addr);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Array has no reset; commit is gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (cmt_en && cmt_we && !cmt_err) begin
      mem[cmt_addr[AW:1]] <= cmt_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (cmt_en) begin
        resp_valid <= 1'b1;
        resp_err   <= cmt_err;
        resp_rdata <= (!cmt_err && !cmt_we) ? mem[cmt_addr[AW:1]] : 16'h0000;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios, randomized
// accesses against an array reference model, and a zero-wait throughput run.
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [15:0] resp_rdata;

  logic        req_valid0, req_we0;
  logic [15:0] req_addr0, req_wdata0;
  logic        req_ready0, resp_valid0, resp_err0, busy0;
  logic [15:0] resp_rdata0;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [256];

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", edge_cnt, e.edge_no);
        chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        chk("busy_in_resp", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Reference: word array with alignment and range rules applied directly.
  function automatic exp_t model(input logic we, input logic [15:0] addr,
                                 input logic [15:0] wd, input int edge_no);
    exp_t e;
    int   idx;
    idx       = int'(addr[15:1]);
    e.err     = addr[0] || (idx >= 256);
    e.rdata   = 16'h0000;
    e.edge_no = edge_no;
    if (!e.err) begin
      if (we) ref_mem[idx] = wd;
      else    e.rdata = ref_mem[idx];
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(model(we, addr, wd, edge_cnt + 1 + W));
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 16'h0; req_wdata0 = 16'h0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
    end
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    #1 chk("ready_before_first_edge", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Store then load
    issue(1'b1, 16'h0004, 16'h1234);
    issue(1'b0, 16'h0004, 16'h0000);
    drain();

    // Misaligned store leaves array untouched
    issue(1'b1, 16'h0005, 16'hBEEF);
    issue(1'b0, 16'h0004, 16'h0000);
    drain();

    // Range boundary
    issue(1'b0, 16'h0200, 16'h0000);
    issue(1'b1, 16'h01FE, 16'hC0DE);
    issue(1'b0, 16'h01FE, 16'h0000);
    drain();

    // Reset during WAIT discards the store
    issue(1'b1, 16'h0010, 16'h5555);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hAAAA;
    chk("idle_ready_before_abort", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 16'h0010, 16'h0000);
    drain();

    // Inputs changing while busy must not alter the latched request
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h7777;
    sb.push_back(model(1'b1, 16'h0020, 16'h7777, edge_cnt + 1 + W));
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0021; req_wdata = 16'h0000;
    @(negedge clk);
    req_addr = 16'h0400;
    drain();
    issue(1'b0, 16'h0020, 16'h0000);
    drain();

    // Pre-write every word the random phase can read
    for (int w = 0; w < 16; w++) issue(1'b1, 16'(w * 2), 16'($urandom));
    for (int w = 248; w < 256; w++) issue(1'b1, 16'(w * 2), 16'($urandom));
    drain();

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: a = 16'($urandom_range(0, 15) * 2);
        5:             a = 16'($urandom_range(0, 15) * 2 + 1);
        6:             a = 16'($urandom_range(248, 255) * 2);
        default:       a = 16'h0200 | (16'($urandom) & 16'hFFFE);
      endcase
      issue(1'($urandom), a, 16'($urandom));
    end
    drain();

    // Zero wait states: req_valid held high, 4 stores then 4 loads
    req_valid0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_we0    = (k < 4);
      req_addr0  = 16'((k % 4) * 2);
      req_wdata0 = 16'hA000 + 16'(k % 4);
      chk("tp_ready_high", {31'd0, req_ready0}, 32'd1);
      chk("tp_valid_low", {31'd0, resp_valid0}, 32'd0);
      @(negedge clk);
      if (k == 7) req_valid0 = 1'b0;
      chk("tp_ready_low", {31'd0, req_ready0}, 32'd0);
      chk("tp_valid_high", {31'd0, resp_valid0}, 32'd1);
      chk("tp_err", {31'd0, resp_err0}, 32'd0);
      chk("tp_rdata", {16'd0, resp_rdata0},
          (k < 4) ? 32'd0 : {16'd0, 16'hA000 + 16'(k % 4)});
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
